uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of one requester byte and of tx_data.
REQ-002 Parameter: N_REQ, 4, number of requesters; fixed at 4 in this revision.
REQ-003 Port: clock  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  per-requester send request; held high until the matching ack.
REQ-006 Port: req_data  input  32  byte for requester k on bits [8k+7:8k]; stable while req[k] is high.
REQ-007 Port: tx_busy  input  1  busy from the UART transmitter state machine.
REQ-008 Port: tx_send  output  1  send request to the transmitter.
REQ-009 Port: tx_data  output  8  byte presented to the transmitter shift register.
REQ-010 Port: grant  output  4  one-hot owner of the current transaction; all-zero when idle.
REQ-011 Port: ack  output  4  one-cycle pulse to requester k when the transmitter has accepted its byte.
REQ-012 Port: active  output  1  high whenever the state is not IDLE.

Function
REQ-013 States SHALL be IDLE, ISSUE, WAIT_DONE and RELEASE, held in a 2-bit registered state.
REQ-014 IDLE, any req bit set at a rising edge: next state ISSUE; grant and tx_data loaded at that edge.
REQ-015 Winner selection SHALL be round-robin, searching upward (mod 4) from pointer ptr, which resets to 0.
REQ-016 tx_send SHALL be high in every ISSUE cycle and low in all other states; registered, so first high one cycle after the winning req is sampled.
REQ-017 ISSUE with tx_busy=1: next state WAIT_DONE; ack[owner] pulses high for exactly the first WAIT_DONE cycle.
REQ-018 ISSUE with tx_busy=0: stay in ISSUE indefinitely; tx_send stays high (covers rts low); no ack.
REQ-019 WAIT_DONE with tx_busy=0: next state RELEASE; otherwise stay in WAIT_DONE.
REQ-020 RELEASE: grant cleared, ptr set to (owner+1) mod 4, next state IDLE unconditionally.
REQ-021 RELEASE lasts exactly one cycle, so that a still-high req from the just-served requester is not re-sampled before it drops.
REQ-022 grant and tx_data SHALL hold constant from ISSUE entry through the RELEASE cycle.
REQ-023 req changes during ISSUE, WAIT_DONE or RELEASE SHALL NOT alter grant, tx_data or the state path.
REQ-024 A req drop by the owner before its ack SHALL NOT abort the transaction; the latched byte is still sent and acked.
REQ-025 Only one ack bit SHALL be high in any cycle; ack bits of non-owners stay 0.
REQ-026 tx_busy=1 while in IDLE SHALL be ignored; arbitration proceeds, and ISSUE waits as in REQ-018.
REQ-027 A single requester SHALL be served back-to-back with at most 2 idle cycles between tx_send pulses.

Reset
REQ-028 While reset is low: state=IDLE, ptr=0, and tx_send, tx_data, grant, ack, active all 0.
REQ-029 Reset assertion mid-transaction SHALL abandon the transaction immediately with no ack; the transmitter is not signalled.
REQ-030 The first arbitration after reset release SHALL use ptr=0.

Verification
REQ-031 req=0001, data0=0x55, tx_busy rising 2 cycles after tx_send -> grant=0001, tx_data=0x55, tx_send high for 2 cycles, ack[0] single pulse.
REQ-032 req=1111 held, each served for one transaction -> service order 0,1,2,3,0; grant never multi-hot.
REQ-033 req=0100, tx_busy held 0 for 50 cycles (rts low) -> tx_send high all 50 cycles, no ack; ack[2] follows busy rise.
REQ-034 req[1] dropped during ISSUE, then tx_busy=1 -> byte still sent, ack[1] pulses, ptr=2.
REQ-035 reset low during WAIT_DONE -> all outputs 0 asynchronously; after release, req=1000 is granted within 1 cycle.
REQ-036 req=0001 after ptr=2, with req=1001 -> requester 3 is granted before requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets four requesters share one UART transmitter.
// A winner's byte is latched on entry to ISSUE and held until RELEASE; the
// transmitter's busy rise is the acceptance handshake that produces the ack.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_REQ  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    tx_busy,
  output logic                    tx_send,
  output logic [DATA_W-1:0]       tx_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic                    active
);

  localparam int unsigned PtrW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StRelease
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     ptr_q, ptr_d;
  logic [PtrW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic                send_q;
  logic                active_q;

  logic                win_found;
  logic [PtrW-1:0]     win_idx;
  logic [PtrW-1:0]     cand;

  // Round-robin search upward from ptr; index arithmetic wraps because N_REQ is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = ptr_q + PtrW'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and datapath update; grant/data only change on IDLE exit and RELEASE exit.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    data_d  = data_q;
    ack_d   = '0;
    unique case (state_q)
      StIdle: begin
        // tx_busy is deliberately ignored here; ISSUE simply waits for it.
        if (win_found) begin
          state_d = StIssue;
          owner_d = win_idx;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          data_d  = req_data[win_idx*DATA_W +: DATA_W];
        end
      end
      StIssue: begin
        // Busy rising is the transmitter accepting the byte.
        if (tx_busy) begin
          state_d = StWaitDone;
          ack_d   = grant_q;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        // Single-cycle gap lets the served requester drop req before IDLE samples again.
        state_d = StIdle;
        grant_d = '0;
        ptr_d   = owner_q + 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction without an ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      ack_q    <= '0;
      send_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      send_q   <= (state_d == StIssue);
      active_q <= (state_d != StIdle);
    end
  end

  assign tx_send = send_q;
  assign tx_data = data_q;
  assign grant   = grant_q;
  assign ack     = ack_q;
  assign active  = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed scenarios plus random request rounds.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic        active;

  uart_tx_arbiter #(.DATA_W(8), .N_REQ(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .tx_busy  (tx_busy),
    .tx_send  (tx_send),
    .tx_data  (tx_data),
    .grant    (grant),
    .ack      (ack),
    .active   (active)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] owner;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         vectors = 0;
  int         miscompares = 0;
  int         model_ptr = 0;
  bit         auto_tx = 1'b0;
  logic [3:0] prev_ack = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: with a fixed set of simultaneous requests that each drop after
  // their ack, service order is the set's members taken cyclically from the pointer.
  task automatic push_round(input logic [3:0] mask, input logic [31:0] data);
    exp_t x;
    int   last;
    last = model_ptr;
    for (int i = 0; i < 4; i++) begin
      int k;
      k = (model_ptr + i) % 4;
      if (mask[k]) begin
        x.owner = 4'(1 << k);
        x.data  = data[8*k +: 8];
        exp_q.push_back(x);
        last = k;
      end
    end
    model_ptr = (last + 1) % 4;
  endtask

  // Monitor: compare each ack pulse against the next expected transaction.
  always @(negedge clock) begin
    if (reset) begin
      check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      if (ack != '0) begin
        check("ack_single_cycle", 32'(prev_ack), 32'd0);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ack: got ack=%b required no ack at %0t", ack, $time);
        end else begin
          e = exp_q.pop_front();
          check("ack_owner", 32'(ack), 32'(e.owner));
          check("grant_owner", 32'(grant), 32'(e.owner));
          check("tx_data", 32'(tx_data), 32'(e.data));
        end
      end
    end
    prev_ack = ack;
  end

  // Transmitter model: accepts each send after a random delay and stays busy a random time.
  initial begin
    forever begin
      @(posedge clock); #1;
      if (auto_tx && reset && tx_send && !tx_busy) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
        tx_busy = 1'b1;
        repeat ($urandom_range(1, 4)) begin @(posedge clock); #1; end
        tx_busy = 1'b0;
      end
    end
  end

  task automatic wait_for_send();
    for (int c = 0; c < 10 && !tx_send; c++) begin
      @(posedge clock); #1;
    end
    check("send_seen", 32'(tx_send), 32'd1);
  endtask

  task automatic wait_ack();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clock); #1;
      if (ack != '0) begin
        req = req & ~ack;
        got = 1'b1;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 20 && active; c++) begin
      @(posedge clock); #1;
    end
    check("back_to_idle", 32'(active), 32'd0);
  endtask

  task automatic run_round(input logic [3:0] mask, input logic [31:0] data);
    push_round(mask, data);
    req_data = data;
    req      = mask;
    for (int c = 0; c < 400 && req != '0; c++) begin
      @(posedge clock); #1;
      req = req & ~ack;
    end
    check("round_done", 32'(req), 32'd0);
    req = '0;
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tx_send"}, 32'(tx_send), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_active"}, 32'(active), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    #2 reset = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock); #1;

    // Single requester, busy rises two cycles after tx_send.
    d = 32'hA5C3_E755;
    push_round(4'b0001, d);
    req_data = d;
    req      = 4'b0001;
    wait_for_send();
    check("r031_grant", 32'(grant), 32'h1);
    check("r031_data", 32'(tx_data), 32'h55);
    @(posedge clock); #1;
    check("r031_send_2nd", 32'(tx_send), 32'd1);
    tx_busy = 1'b1;
    @(posedge clock); #1;
    check("r031_send_low", 32'(tx_send), 32'd0);
    check("r031_ack", 32'(ack), 32'h1);
    req = req & ~ack;
    @(posedge clock); #1;
    check("r031_ack_pulse", 32'(ack), 32'd0);
    tx_busy = 1'b0;
    wait_idle();

    // Transmitter not ready for 50 cycles: tx_send held, no ack.
    d = $urandom;
    push_round(4'b0100, d);
    req_data = d;
    req      = 4'b0100;
    wait_for_send();
    for (int c = 0; c < 50; c++) begin
      check("r033_send_held", 32'(tx_send), 32'd1);
      check("r033_no_ack", 32'(ack), 32'd0);
      @(posedge clock); #1;
    end
    tx_busy = 1'b1;
    @(posedge clock); #1;
    check("r033_ack", 32'(ack), 32'h4);
    req = req & ~ack;
    tx_busy = 1'b0;
    wait_idle();

    // Owner drops req during ISSUE; the latched byte is still sent and acked.
    d = $urandom;
    push_round(4'b0010, d);
    req_data = d;
    req      = 4'b0010;
    wait_for_send();
    req = '0;
    @(posedge clock); #1;
    check("r034_send_kept", 32'(tx_send), 32'd1);
    tx_busy = 1'b1;
    wait_ack();
    tx_busy = 1'b0;
    wait_idle();

    // Pointer now 2: requester 3 must precede requester 0.
    auto_tx = 1'b1;
    run_round(4'b1001, $urandom);
    auto_tx = 1'b0;

    // Reset in WAIT_DONE, then first arbitration uses pointer 0.
    d = $urandom;
    push_round(4'b0001, d);
    req_data = d;
    req      = 4'b0001;
    wait_for_send();
    tx_busy = 1'b1;
    wait_ack();
    @(posedge clock); #3;
    reset = 1'b0;
    #1 check_all_zero("r035_async");
    tx_busy   = 1'b0;
    req       = '0;
    model_ptr = 0;
    @(negedge clock);
    reset = 1'b1;
    d = $urandom;
    push_round(4'b1000, d);
    req_data = d;
    req      = 4'b1000;
    @(posedge clock); #1;
    check("r035_grant", 32'(grant), 32'h8);
    tx_busy = 1'b1;
    wait_ack();
    tx_busy = 1'b0;
    wait_idle();

    // All four requesting with pointer 0: order 0,1,2,3 then 0 again.
    auto_tx = 1'b1;
    run_round(4'b1111, $urandom);
    run_round(4'b0001, $urandom);

    // Random request sets.
    for (int r = 0; r < 40; r++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      run_round(m, $urandom);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
